// File: rtl/lcd_bus_arbiter.sv
// ---------------------------------------------------------------------------
// lcd_bus_arbiter
//
// Shares one HD44780-style LCD write bus between two writers. Requester 0 is
// the input-echo writer and requester 1 is the result writer. A write is
// performed as a fixed sequence: rs/data settle (SETUP), enable pulse
// (PULSE), rs/data hold (HOLD), then a command execution wait (WAIT) whose
// length depends on the byte written. The winner receives a one-cycle ack
// in DONE.
//
// Optional feature macro:
//   LCD_ARB_RR_EN  - round-robin arbitration between simultaneous requests
//                    (default build: fixed priority, req1 over req0)
//
// Parameters:
//   T_SETUP  cycles rs/data are stable before en rises
//   T_EN     cycles en is high
//   T_HOLD   cycles rs/data are stable after en falls
//   T_EXEC   post-write wait for normal commands and data
//   T_CLR    post-write wait for clear (0x01) / home (0x02) commands
//
// Ports:
//   clk            system clock, rising edge
//   reset_n        asynchronous active-low reset
//   req0 / req1    write requests, held until the matching ack
//   rs0, data0     register select / byte of requester 0
//   rs1, data1     register select / byte of requester 1
//   ack0 / ack1    one-cycle write-complete pulse to the owner
//   data, rs, rw,  LCD bus (rw is always 0: write only)
//   en
//   busy           high whenever a transaction is in progress
//   owner          requester granted the current or last transaction
// ---------------------------------------------------------------------------
module lcd_bus_arbiter #(
  parameter int T_SETUP = 2,
  parameter int T_EN    = 25,
  parameter int T_HOLD  = 2,
  parameter int T_EXEC  = 2500,
  parameter int T_CLR   = 100000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req0,
  input  logic       req1,
  input  logic       rs0,
  input  logic       rs1,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  output logic       ack0,
  output logic       ack1,
  output logic [7:0] data,
  output logic       rs,
  output logic       rw,
  output logic       en,
  output logic       busy,
  output logic       owner
);

  // Largest phase length decides the counter width; the counter only ever
  // holds (length - 1), so this never wraps.
  localparam int MAX_A = (T_SETUP > T_EN)   ? T_SETUP : T_EN;
  localparam int MAX_B = (T_HOLD  > T_EXEC) ? T_HOLD  : T_EXEC;
  localparam int MAX_C = (MAX_A   > MAX_B)  ? MAX_A   : MAX_B;
  localparam int MAX_T = (MAX_C   > T_CLR)  ? MAX_C   : T_CLR;
  localparam int CNT_W = (MAX_T > 1) ? $clog2(MAX_T + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_WAIT,
    S_DONE
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   phase_cnt;
  logic [CNT_W-1:0]   load_val;
  logic               phase_done;
  logic               grant;
  logic               winner;
  logic               is_clear;

  // A grant happens only from IDLE, on the first cycle any request is seen.
  assign grant      = (state == S_IDLE) && (req0 || req1);
  assign phase_done = (phase_cnt == '0);

  // Clear-display and return-home are slow instructions; they are
  // recognised from the latched byte so input changes after the grant
  // cannot alter the wait.
  assign is_clear = !rs && ((data == 8'h01) || (data == 8'h02));

`ifdef LCD_ARB_RR_EN
  // Round-robin pointer: remembers the requester granted last so that on a
  // tie the other one wins. A lone request always wins.
  logic rr_ptr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= 1'b0;
    end else if (grant) begin
      rr_ptr <= winner;
    end
  end

  assign winner = (req0 && req1) ? ~rr_ptr : req1;
`else
  // Fixed priority: the result writer beats the echo writer.
  assign winner = req1;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: each timed phase advances once its counter is spent.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (grant)      state_next = S_SETUP;
      S_SETUP: if (phase_done) state_next = S_PULSE;
      S_PULSE: if (phase_done) state_next = S_HOLD;
      S_HOLD:  if (phase_done) state_next = S_WAIT;
      S_WAIT:  if (phase_done) state_next = S_DONE;
      S_DONE:                  state_next = S_IDLE;
      default:                 state_next = S_IDLE;
    endcase
  end

  // Length of the phase being entered, expressed as (cycles - 1) so the
  // phase ends on the cycle the counter reads zero.
  always_comb begin
    load_val = '0;
    case (state_next)
      S_SETUP: load_val = CNT_W'(T_SETUP - 1);
      S_PULSE: load_val = CNT_W'(T_EN - 1);
      S_HOLD:  load_val = CNT_W'(T_HOLD - 1);
      S_WAIT:  load_val = is_clear ? CNT_W'(T_CLR - 1) : CNT_W'(T_EXEC - 1);
      default: load_val = '0;
    endcase
  end

  // Phase counter reloads on every state change and counts down otherwise.
  // The bus registers and owner are captured once, at the grant, so the
  // requester's inputs are free to change for the rest of the transaction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_cnt <= '0;
      data      <= 8'h00;
      rs        <= 1'b0;
      owner     <= 1'b0;
    end else begin
      if (state_next != state) begin
        phase_cnt <= load_val;
      end else if (!phase_done) begin
        phase_cnt <= phase_cnt - CNT_W'(1);
      end
      if (grant) begin
        owner <= winner;
        data  <= winner ? data1 : data0;
        rs    <= winner ? rs1 : rs0;
      end
    end
  end

  // Outputs decoded from the state, so reset removes en and ack at once.
  always_comb begin
    en   = (state == S_PULSE);
    busy = (state != S_IDLE);
    ack0 = (state == S_DONE) && !owner;
    ack1 = (state == S_DONE) &&  owner;
    rw   = 1'b0;
  end

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_lcd_bus_arbiter
//
// Self-checking bench for lcd_bus_arbiter. Timing parameters are shortened
// (each distinct) so clear-command waits fit in a short run. A driver issues
// directed and random write requests and pushes the expected transactions,
// in arbitration order, into a scoreboard queue. A monitor watches the LCD
// bus, measures each phase and compares against the queue on every ack.
// Define LCD_ARB_RR_EN for both the bench and the design to check the
// round-robin build.
// ---------------------------------------------------------------------------
module tb_lcd_bus_arbiter;

  localparam int P_SETUP = 3;
  localparam int P_EN    = 7;
  localparam int P_HOLD  = 2;
  localparam int P_EXEC  = 23;
  localparam int P_CLR   = 71;
  localparam int TIMEOUT = 1000;

`ifdef LCD_ARB_RR_EN
  localparam bit RR_MODEL = 1'b1;
`else
  localparam bit RR_MODEL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       req0 = 1'b0;
  logic       req1 = 1'b0;
  logic       rs0 = 1'b0;
  logic       rs1 = 1'b0;
  logic [7:0] data0 = 8'h00;
  logic [7:0] data1 = 8'h00;
  logic       ack0;
  logic       ack1;
  logic [7:0] data;
  logic       rs;
  logic       rw;
  logic       en;
  logic       busy;
  logic       owner;

  typedef struct {
    bit         owner;
    bit         rs;
    logic [7:0] data;
    int         gap;
  } txn_t;

  txn_t sb[$];
  int   tests = 0;
  int   fails = 0;
  bit   lastOwner = 1'b0;
  bit   hung = 1'b0;

  lcd_bus_arbiter #(
    .T_SETUP(P_SETUP),
    .T_EN   (P_EN),
    .T_HOLD (P_HOLD),
    .T_EXEC (P_EXEC),
    .T_CLR  (P_CLR)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .req0   (req0),
    .req1   (req1),
    .rs0    (rs0),
    .rs1    (rs1),
    .data0  (data0),
    .data1  (data1),
    .ack0   (ack0),
    .ack1   (ack1),
    .data   (data),
    .rs     (rs),
    .rw     (rw),
    .en     (en),
    .busy   (busy),
    .owner  (owner)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic txn_t mkTxn(input bit o, input bit r, input logic [7:0] d, input int g);
    txn_t t;
    t.owner = o;
    t.rs    = r;
    t.data  = d;
    t.gap   = g;
    return t;
  endfunction

  // Post-write wait from the command rules: clear/home are slow.
  function automatic int waitLen(input bit r, input logic [7:0] d);
    return (!r && (d == 8'h01 || d == 8'h02)) ? P_CLR : P_EXEC;
  endfunction

  function automatic logic [7:0] pickData();
    if ($urandom_range(0, 3) == 0) return 8'($urandom_range(1, 2));
    return 8'($urandom);
  endfunction

  // mode 0: req0 alone; 1: req1 alone; 2: both on the same edge;
  // 3: req1 then req0 after k cycles; 4: req0 then req1 after k cycles.
  // scribble: owner changes rs/data (and maybe drops req) while en is high.
  task automatic applyStimulus(input int mode, input bit r0, input logic [7:0] d0,
                               input bit r1, input logic [7:0] d1, input int k,
                               input bit scribble);
    bit need0, need1, got0, got1, lateDone, first;
    int cnt;
    if (hung) return;
    need0 = (mode != 1);
    need1 = (mode != 0);
    got0  = 1'b0;
    got1  = 1'b0;
    cnt   = 0;
    rs0   = r0;
    data0 = d0;
    rs1   = r1;
    data1 = d1;
    case (mode)
      0: begin
        sb.push_back(mkTxn(1'b0, r0, d0, -1));
        lastOwner = 1'b0;
      end
      1: begin
        sb.push_back(mkTxn(1'b1, r1, d1, -1));
        lastOwner = 1'b1;
      end
      2: begin
        first = RR_MODEL ? ~lastOwner : 1'b1;
        sb.push_back(mkTxn(first, first ? r1 : r0, first ? d1 : d0, -1));
        sb.push_back(mkTxn(~first, first ? r0 : r1, first ? d0 : d1, 2));
        lastOwner = ~first;
      end
      3: begin
        sb.push_back(mkTxn(1'b1, r1, d1, -1));
        sb.push_back(mkTxn(1'b0, r0, d0, 2));
        lastOwner = 1'b0;
      end
      default: begin
        sb.push_back(mkTxn(1'b0, r0, d0, -1));
        sb.push_back(mkTxn(1'b1, r1, d1, 2));
        lastOwner = 1'b1;
      end
    endcase
    req0 = (mode == 0 || mode == 2 || mode == 4);
    req1 = (mode == 1 || mode == 2 || mode == 3);
    lateDone = (mode < 3);
    while (!((got0 || !need0) && (got1 || !need1))) begin
      @(negedge clk);
      cnt++;
      if (cnt > TIMEOUT) begin
        tests++;
        fails++;
        $display("[TB] FAIL txn_timeout: mode %0d still waiting after %0d cycles, expected ack within %0d",
                 mode, cnt, TIMEOUT);
        hung = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        sb.delete();
        break;
      end
      if (!lateDone && cnt == k) begin
        if (mode == 3) req0 = 1'b1;
        else           req1 = 1'b1;
        lateDone = 1'b1;
      end
      if (ack0 && need0 && !got0) begin
        got0 = 1'b1;
        req0 = 1'b0;
      end
      if (ack1 && need1 && !got1) begin
        got1 = 1'b1;
        req1 = 1'b0;
      end
      if (scribble && en) begin
        if (owner == 1'b0 && !got0) begin
          data0 = 8'($urandom);
          rs0   = 1'($urandom_range(0, 1));
          if ($urandom_range(0, 3) == 0) req0 = 1'b0;
        end else if (owner == 1'b1 && !got1) begin
          data1 = 8'($urandom);
          rs1   = 1'($urandom_range(0, 1));
          if ($urandom_range(0, 3) == 0) req1 = 1'b0;
        end
      end
    end
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  // Monitor: measures each transaction on the bus and scores it at its ack.
  initial begin : monitor
    int         cyc;
    int         riseCyc;
    int         enRise;
    int         enFall;
    int         enLen;
    int         lastAck;
    bit         prevBusy;
    bit         prevEn;
    bit         stable;
    bit         haveLastAck;
    logic [7:0] busData;
    logic       busRs;
    txn_t       e;
    cyc = 0; riseCyc = 0; enRise = -1; enFall = -1; enLen = 0; lastAck = 0;
    prevBusy = 1'b0; prevEn = 1'b0; stable = 1'b1; haveLastAck = 1'b0;
    busData = 8'h00; busRs = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset_n) begin
        prevBusy    = 1'b0;
        prevEn      = 1'b0;
        haveLastAck = 1'b0;
        continue;
      end
      if (busy && !prevBusy) begin
        riseCyc = cyc;
        enRise  = -1;
        enFall  = -1;
        enLen   = 0;
        stable  = 1'b1;
        busData = data;
        busRs   = rs;
      end
      if (busy && (data !== busData || rs !== busRs)) stable = 1'b0;
      if (en) begin
        if (!prevEn) enRise = cyc;
        enLen++;
      end else if (prevEn) begin
        enFall = cyc;
      end
      if (ack0 || ack1) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected_ack: got ack0=%0d ack1=%0d, expected no ack", ack0, ack1);
        end else begin
          e = sb.pop_front();
          checkOutput("ack_exclusive", int'(ack0 & ack1), 0);
          checkOutput("ack_owner", ack1 ? 1 : 0, e.owner);
          checkOutput("owner_port", owner, e.owner);
          checkOutput("bus_data", busData, e.data);
          checkOutput("bus_rs", busRs, e.rs);
          checkOutput("bus_stable", stable, 1);
          checkOutput("setup_cycles", enRise - riseCyc, P_SETUP);
          checkOutput("en_cycles", enLen, P_EN);
          checkOutput("hold_wait_cycles", cyc - enFall, P_HOLD + waitLen(e.rs, e.data));
          checkOutput("rw_low", rw, 0);
          if (e.gap >= 0 && haveLastAck) checkOutput("regrant_gap", riseCyc - lastAck, e.gap);
        end
        lastAck     = cyc;
        haveLastAck = 1'b1;
      end
      prevBusy = busy;
      prevEn   = en;
    end
  end

  initial begin : stimulus
    int         cnt;
    int         m;
    int         k;
    bit         r0;
    bit         r1;
    logic [7:0] d0;
    logic [7:0] d1;

    #3;
    checkOutput("reset_en", en, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_ack0", ack0, 0);
    checkOutput("reset_ack1", ack1, 0);
    checkOutput("reset_data", data, 0);
    checkOutput("reset_rs", rs, 0);
    checkOutput("reset_owner", owner, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Directed: single writes, clear wait, ties, mid-pulse input change,
    // and a request arriving while the bus is busy.
    applyStimulus(0, 1'b1, 8'h35, 1'b0, 8'h00, 1, 1'b0);
    applyStimulus(1, 1'b0, 8'h00, 1'b0, 8'h01, 1, 1'b0);
    applyStimulus(2, 1'b1, 8'h41, 1'b1, 8'h42, 1, 1'b0);
    applyStimulus(2, 1'b0, 8'h0C, 1'b1, 8'h43, 1, 1'b0);
    applyStimulus(0, 1'b1, 8'h35, 1'b0, 8'h2B, 1, 1'b1);
    applyStimulus(3, 1'b1, 8'h50, 1'b1, 8'h51, 4, 1'b0);

    for (int n = 0; n < 40; n++) begin
      m  = $urandom_range(0, 4);
      k  = $urandom_range(1, P_SETUP + P_EN);
      r0 = 1'($urandom_range(0, 1));
      r1 = 1'($urandom_range(0, 1));
      d0 = pickData();
      d1 = pickData();
      applyStimulus(m, r0, d0, r1, d1, k, 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of an enable pulse aborts without an ack.
    if (!hung) begin
      rs1   = 1'b1;
      data1 = 8'hA7;
      sb.push_back(mkTxn(1'b1, 1'b1, 8'hA7, -1));
      req1  = 1'b1;
      cnt   = 0;
      while (!en && cnt < 100) begin
        @(negedge clk);
        cnt++;
      end
      checkOutput("reach_pulse", en, 1);
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      checkOutput("abort_en", en, 0);
      checkOutput("abort_busy", busy, 0);
      checkOutput("abort_ack0", ack0, 0);
      checkOutput("abort_ack1", ack1, 0);
      checkOutput("abort_data", data, 0);
      checkOutput("abort_rs", rs, 0);
      checkOutput("abort_owner", owner, 0);
      sb.delete();
      req1      = 1'b0;
      lastOwner = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (4) @(negedge clk);
      checkOutput("idle_after_abort", busy, 0);
      applyStimulus(0, 1'b0, 8'h02, 1'b0, 8'h00, 1, 1'b0);
      applyStimulus(2, 1'b1, 8'h61, 1'b0, 8'h01, 1, 1'b0);
    end

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL pending_txns: got %0d outstanding, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lcd_bus_arbiter.md
LCD_BUS_ARBITER -- requirements
Module: lcd_bus_arbiter

Interface
- REQ-001 Parameter: T_SETUP, 2, cycles rs/data held stable before en rises.
- REQ-002 Parameter: T_EN, 25, cycles en held high (500 ns at 50 MHz).
- REQ-003 Parameter: T_HOLD, 2, cycles rs/data held stable after en falls.
- REQ-004 Parameter: T_EXEC, 2500, post-write wait cycles for normal commands and data (50 us).
- REQ-005 Parameter: T_CLR, 100000, post-write wait cycles for clear/home commands (2 ms).
- REQ-006 Port: clk  in  1  system clock, rising edge.
- REQ-007 Port: reset_n  in  1  asynchronous, active-low reset.
- REQ-008 Port: req0 / req1  in  1 each  write request; req0 = input-echo writer, req1 = result writer.
- REQ-009 Port: rs0, rs1  in  1 each; data0, data1  in  8 each  requested register select and byte.
- REQ-010 Port: ack0 / ack1  out  1 each  one-cycle write-complete pulse.
- REQ-011 Port: data  out  8; rs  out  1; rw  out  1; en  out  1  LCD bus.
- REQ-012 Port: busy  out  1  high in every state except IDLE.
- REQ-013 Port: owner  out  1  index of the requester granted the current or last transaction.

Function
- REQ-014 The block SHALL be an FSM with states IDLE, SETUP, PULSE, HOLD, WAIT, DONE.
- REQ-015 In IDLE with any req high, the block SHALL pick a winner, latch its rs/data into the output registers, set owner, and enter SETUP on the same edge.
- REQ-016 Arbitration without LCD_ARB_RR_EN SHALL be fixed priority: req1 wins over req0.
- REQ-017 SETUP SHALL last T_SETUP cycles, PULSE T_EN cycles with en=1, and HOLD T_HOLD cycles; en SHALL be 0 in every other state.
- REQ-018 WAIT SHALL last T_CLR cycles when the latched rs=0 and data is 8'h01 or 8'h02, and T_EXEC cycles otherwise.
- REQ-019 DONE SHALL last exactly one cycle, assert ack of owner only, and then return to IDLE.
- REQ-020 A requester SHALL hold req, rs and data until its ack; the requester deasserts req on the edge ending DONE, so it is not regranted.
- REQ-021 Changes to rs/data inputs or deassertion of req after the grant SHALL NOT affect the bus; the transaction SHALL complete and ack SHALL still be issued.
- REQ-022 Requests arriving while busy=1 SHALL wait; arbitration SHALL occur only in IDLE.
- REQ-023 rw SHALL be constant 0.
- REQ-024 The phase counter SHALL be wide enough for max(T_CLR, T_EXEC) and SHALL reload on each state entry without wrap.

Reset
- REQ-025 reset_n low SHALL immediately force state=IDLE, en=0, rs=0, data=8'h00, ack0=ack1=0, busy=0, owner=0, counter=0, and round-robin pointer=0.
- REQ-026 Reset asserted mid-transaction SHALL abort the transaction with no ack, even if en was high.

Configuration
- REQ-027 With macro LCD_ARB_RR_EN defined, arbitration SHALL be round-robin: on simultaneous requests the requester not granted last wins; a single request always wins.
- REQ-028 Without LCD_ARB_RR_EN, fixed priority (REQ-016) SHALL apply and the pointer logic SHALL NOT be built.

Verification
- REQ-029 Scenario 1: req0=1, rs0=1, data0=8'h35 from IDLE -> en high exactly 25 cycles starting 2 cycles after grant, data=8'h35, rs=1; ack0 pulses once after 2500 WAIT cycles; ack1 stays 0.
- REQ-030 Scenario 2: req1=1, rs1=0, data1=8'h01 -> WAIT lasts 100000 cycles before ack1.
- REQ-031 Scenario 3: req0 and req1 rise on the same edge, both held through completion -> fixed priority: owner=1 first, then 0; with LCD_ARB_RR_EN, owner alternates 1,0,1,0 over four transactions.
- REQ-032 Scenario 4: reset_n pulsed low during PULSE -> en drops in the same cycle, no ack, busy=0; next request starts a fresh SETUP.
- REQ-033 Scenario 5: data0 changed from 8'h35 to 8'h2B during PULSE -> bus data stays 8'h35 through HOLD.
- REQ-034 Scenario 6: req0 rises while busy serving req1 -> req0 granted on the first IDLE cycle after DONE.
